icache_mem_burst_bridge: RTL and testbench
==========================================

// Module: icache_mem_burst_bridge
// PURPOSE
//  Sits directly downstream of the instruction cache's memory-read port.
//  Takes one 32-byte line-read request and issues BEATS single-word reads to a word-wide memory port.
//  Buffers the returned words in a small FIFO and replays them as a burst with valid/ready/last.
//  Credit control means the memory response port never needs backpressure.
// PARAMETERS
//  BEATS       8   words per line; line = BEATS*4 bytes; power of two
//  FIFO_DEPTH  4   response FIFO entries; also the max words in flight; >=2, power of two
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  line_req_valid  in   1   line-read request valid (from cache)
//  line_req_addr   in   32  line address; bits[4:0] ignored, treated as 0
//  line_req_ready  out  1   bridge can accept a line request
//  line_rsp_valid  out  1   burst beat valid (to cache)
//  line_rsp_data   out  32  burst beat data
//  line_rsp_last   out  1   current beat is beat BEATS-1
//  line_rsp_ready  in   1   cache accepts current beat
//  mem_req_valid   out  1   word-read request valid
//  mem_req_addr    out  32  word address, 4-byte aligned
//  mem_req_ready   in   1   memory accepts word request
//  mem_rsp_valid   in   1   read word returned; in order; no backpressure
//  mem_rsp_data    in   32  returned word
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; issue_cnt, ret_cnt, outstanding, FIFO pointers/count cleared; base=0.
//   - Next cycle: line_req_ready=1, mem_req_valid=0, line_rsp_valid=0, line_rsp_last=0, line_rsp_data=0.
//   - Mid-burst reset drops all in-flight and buffered words. Late mem_rsp_valid after reset is ignored (state IDLE).
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE:
//   - IDLE: line_req_ready=1. On line_req_valid: latch base={addr[31:5],5'b0}, clear counters, go ISSUE.
//   - ISSUE: mem_req_valid = (fifo_count+outstanding < FIFO_DEPTH).
//     mem_req_addr = base + issue_cnt*4, 32-bit modulo; stable while valid && !ready.
//     On a handshake with issue_cnt==BEATS-1 go DRAIN; otherwise issue_cnt++.
//   - DRAIN: mem_req_valid=0. On a pop with ret_cnt==BEATS-1 go IDLE.
//   - A final pop in ISSUE is impossible: all issues precede all returns.
//   - line_req_ready=0 in ISSUE and DRAIN; only one line in flight.
//  Outstanding counter:
//   - +1 on mem_req handshake, -1 on mem_rsp_valid; both in one cycle leaves it unchanged.
//   - Width clog2(FIFO_DEPTH)+1.
//  FIFO:
//   - Push on mem_rsp_valid when state!=IDLE. The credit rule guarantees it is never full at a push.
//   - line_rsp_valid = !empty && state!=IDLE; line_rsp_data = head entry.
//   - Pop on line_rsp_valid && line_rsp_ready; ret_cnt++.
//   - No bypass: a word is visible on line_rsp the cycle after its mem_rsp_valid.
//   - Simultaneous push+pop: count unchanged, both pointers advance.
//   - Pointers wrap modulo FIFO_DEPTH.
//  line_rsp_last = line_rsp_valid && ret_cnt==BEATS-1; never asserted on any other beat.
//  Credit check uses the registered count and ignores a same-cycle pop (conservative).
//  Latency:
//   - Line request accepted at cycle T; first mem_req_valid at T+1.
//   - Memory response latency L cycles: first line beat at T+2+L.
//   - With ready always high and L=1, one beat per cycle thereafter.
// TESTING
//  1. addr=0x0000_1234, mem ready=1, L=1, line_rsp_ready=1
//     -> mem addrs 0x1220,0x1224..0x123C; 8 beats in order; last only on beat 8; line_req_ready=1 after.
//  2. line_rsp_ready=0 throughout a request
//     -> exactly 4 mem handshakes, then mem_req_valid=0.
//     Raising ready -> remaining 4 issued; all 8 data words in order.
//  3. mem_req_ready toggling 1/0, L=3
//     -> mem_req_addr/valid stable while stalled; no duplicate or skipped address; 8 beats.
//  4. Second line_req_valid held high during a burst
//     -> line_req_ready=0 until the cycle after the last pop; second line base 0x40 then issues 0x40..0x5C.
//  5. rst pulsed after 3 beats delivered, memory keeps returning 2 words
//     -> next cycle all outputs at reset values, stray words ignored; new request 0x80 returns beat 0 first.
//  6. addr=0xFFFF_FFE4
//     -> mem addrs 0xFFFF_FFE0..0xFFFF_FFFC; no wrap past 0xFFFF_FFFC; last on 8th beat.

Source files
------------

// File: rtl/icache_mem_burst_bridge.sv
// Turns one instruction-cache line read into BEATS word reads and replays the returned
// words as a valid/ready/last burst. Word requests are credit-limited so that the memory
// response port never needs backpressure.
module icache_mem_burst_bridge #(
    parameter int BEATS      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_req_valid,
    input  logic [31:0] line_req_addr,
    output logic        line_req_ready,
    output logic        line_rsp_valid,
    output logic [31:0] line_rsp_data,
    output logic        line_rsp_last,
    input  logic        line_rsp_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [BW-1:0] LAST_BEAT   = BW'(BEATS - 1);
    localparam logic [SW-1:0] DEPTH_LIMIT = SW'(FIFO_DEPTH);
    localparam logic [31:0]   LINE_MASK   = ~(32'(BEATS * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   base;
    logic [BW-1:0] issue_cnt;
    logic [BW-1:0] ret_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic          mem_hs;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [SW-1:0] in_use;

    // Every output is decoded from registered state only; there is no input-to-output path.
    assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_ok      = in_use < DEPTH_LIMIT;
    assign line_req_ready = (state == IDLE);
    assign mem_req_valid  = (state == ISSUE) && credit_ok;
    assign mem_req_addr   = base + 32'({issue_cnt, 2'b00});
    assign line_rsp_valid = (fifo_count != '0) && (state != IDLE);
    assign line_rsp_data  = line_rsp_valid ? fifo_mem[rd_ptr] : 32'd0;
    assign line_rsp_last  = line_rsp_valid && (ret_cnt == LAST_BEAT);

    assign mem_hs = mem_req_valid && mem_req_ready;
    assign push   = mem_rsp_valid && (state != IDLE);
    assign pop    = line_rsp_valid && line_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= 32'd0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_req_valid) begin
                        base      <= line_req_addr & LINE_MASK;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_hs) begin
                        if (issue_cnt == LAST_BEAT) begin
                            state <= DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (ret_cnt == LAST_BEAT)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                ret_cnt <= ret_cnt + BW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            // Responses arriving while idle belong to an aborted line and are not counted.
            case ({mem_hs, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_icache_mem_burst_bridge.sv
// Directed bench for icache_mem_burst_bridge: a small in-order memory with configurable
// latency answers word reads, and whole-line bursts are compared against hand-computed values.
module tb_icache_mem_burst_bridge;

    localparam int BEATS = 8;
    localparam logic [31:0] DATA_KEY = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_req_valid = 1'b0;
    logic [31:0] line_req_addr = 32'd0;
    logic        line_req_ready;
    logic        line_rsp_valid;
    logic [31:0] line_rsp_data;
    logic        line_rsp_last;
    logic        line_rsp_ready = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'd0;

    icache_mem_burst_bridge #(.BEATS(BEATS), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .line_req_valid (line_req_valid),
        .line_req_addr  (line_req_addr),
        .line_req_ready (line_req_ready),
        .line_rsp_valid (line_rsp_valid),
        .line_rsp_data  (line_rsp_data),
        .line_rsp_last  (line_rsp_last),
        .line_rsp_ready (line_rsp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] addr2;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] req_addr;
        int          lat;
        bit          toggle;
        logic [31:0] exp_base;
    } vec_t;

    pend_t       pend_q[$];
    logic [31:0] issued_q[$];
    logic [31:0] data_q[$];
    logic        last_q[$];
    vec_t        vecs[5];

    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          mem_toggle = 1'b0;
    logic [31:0] cur_base = 32'd0;
    int          accept_cyc;
    int          first_req_cyc;
    int          first_beat_cyc;
    int          last_beat_cyc;
    int          ready_high_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic clearRecords();
        issued_q.delete();
        data_q.delete();
        last_q.delete();
        first_req_cyc  = -1;
        first_beat_cyc = -1;
        last_beat_cyc  = -1;
        ready_high_cnt = 0;
    endtask

    // One clock: log the handshakes that happen at the coming edge, then play the memory model.
    task automatic tick();
        bit    stalled;
        bit    was_rst;
        pend_t p;
        stalled = (mem_req_valid === 1'b1) && !mem_req_ready;
        was_rst = rst;
        if (mem_req_valid === 1'b1 && first_req_cyc < 0) first_req_cyc = cyc;
        if (line_req_ready === 1'b1) ready_high_cnt++;
        if (mem_req_valid === 1'b1 && mem_req_ready) begin
            pend_q.push_back('{mem_req_addr, mem_req_addr ^ DATA_KEY, cyc + lat});
            issued_q.push_back(mem_req_addr);
        end
        if (line_rsp_valid === 1'b1) begin
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            if (line_rsp_ready) begin
                data_q.push_back(line_rsp_data);
                last_q.push_back(line_rsp_last);
                last_beat_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stalled && !was_rst) begin
            checkOutput("stall_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("stall_addr", mem_req_addr, cur_base + 32'(4 * issued_q.size()));
        end
        if (mem_toggle) mem_req_ready = !mem_req_ready;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = p.addr2;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int l, input bit toggle, input bit rsp_rdy);
        bit accepted;
        int n;
        clearRecords();
        lat            = l;
        mem_toggle     = 1'b0;
        mem_req_ready  = 1'b1;
        line_rsp_ready = rsp_rdy;
        cur_base       = addr & 32'hFFFF_FFE0;
        line_req_valid = 1'b1;
        line_req_addr  = addr;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            if (line_req_ready === 1'b1) begin
                accepted   = 1'b1;
                accept_cyc = cyc;
            end
            tick();
            n++;
        end
        line_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        mem_toggle     = toggle;
        if (!accepted) checkOutput("req_accept", 32'd0, 32'd1);
    endtask

    task automatic collectLine(input int budget);
        int n;
        n = 0;
        while (data_q.size() < BEATS && n < budget) begin
            tick();
            n++;
        end
        checkOutput("beat_count", 32'(data_q.size()), 32'(BEATS));
    endtask

    task automatic checkLine(input string tag, input logic [31:0] exp_base);
        checkOutput({tag, "_issue_count"}, 32'(issued_q.size()), 32'(BEATS));
        for (int i = 0; i < BEATS; i++) begin
            if (i < issued_q.size())
                checkOutput({tag, "_mem_addr"}, issued_q[i], exp_base + 32'(4 * i));
            if (i < data_q.size()) begin
                checkOutput({tag, "_beat_data"}, data_q[i], (exp_base + 32'(4 * i)) ^ DATA_KEY);
                checkOutput({tag, "_beat_last"}, 32'(last_q[i]), (i == BEATS - 1) ? 32'd1 : 32'd0);
            end
        end
        checkOutput({tag, "_req_ready_after"}, 32'(line_req_ready), 32'd1);
        checkOutput({tag, "_mem_valid_after"}, 32'(mem_req_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int stray_seen;

        vecs[0] = '{32'h0000_1234, 1, 1'b0, 32'h0000_1220};
        vecs[1] = '{32'h0000_5678, 3, 1'b1, 32'h0000_5660};
        vecs[2] = '{32'hFFFF_FFE4, 1, 1'b0, 32'hFFFF_FFE0};
        vecs[3] = '{32'h0000_0020, 2, 1'b0, 32'h0000_0020};
        vecs[4] = '{32'hABCD_EF1F, 2, 1'b1, 32'hABCD_EF00};

        clearRecords();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_req_ready", 32'(line_req_ready), 32'd1);
        checkOutput("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_rsp_valid", 32'(line_rsp_valid), 32'd0);
        checkOutput("rst_rsp_last", 32'(line_rsp_last), 32'd0);
        checkOutput("rst_rsp_data", line_rsp_data, 32'd0);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].req_addr, vecs[v].lat, vecs[v].toggle, 1'b1);
            collectLine(200);
            mem_toggle    = 1'b0;
            mem_req_ready = 1'b1;
            checkLine($sformatf("vec%0d", v), vecs[v].exp_base);
            checkOutput("first_req_latency", 32'(first_req_cyc - accept_cyc), 32'd1);
            checkOutput("first_beat_latency", 32'(first_beat_cyc - accept_cyc), 32'(2 + vecs[v].lat));
            if (!vecs[v].toggle && vecs[v].lat == 1)
                checkOutput("beat_per_cycle", 32'(last_beat_cyc - first_beat_cyc), 32'(BEATS - 1));
            tick();
        end

        // Cache stalled: only FIFO_DEPTH words may be requested before issuing stops.
        applyStimulus(32'h0000_0100, 1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("credit_issues", 32'(issued_q.size()), 32'd4);
        checkOutput("credit_valid_low", 32'(mem_req_valid), 32'd0);
        checkOutput("credit_no_pops", 32'(data_q.size()), 32'd0);
        checkOutput("credit_head_data", line_rsp_data, 32'h0000_0100 ^ DATA_KEY);
        line_rsp_ready = 1'b1;
        collectLine(200);
        checkLine("credit", 32'h0000_0100);
        tick();

        // A second request held high during a burst waits until the line is fully drained.
        applyStimulus(32'h0000_0000, 1, 1'b0, 1'b1);
        ready_high_cnt = 0;
        line_req_valid = 1'b1;
        line_req_addr  = 32'h0000_0040;
        collectLine(200);
        checkOutput("busy_req_ready_low", 32'(ready_high_cnt), 32'd0);
        checkLine("first_line", 32'h0000_0000);
        clearRecords();
        accept_cyc = cyc;
        cur_base   = 32'h0000_0040;
        tick();
        line_req_valid = 1'b0;
        collectLine(200);
        checkLine("second_line", 32'h0000_0040);
        checkOutput("second_req_latency", 32'(first_req_cyc - accept_cyc), 32'd1);
        tick();

        // Reset in the middle of a burst; words still in flight must be dropped.
        applyStimulus(32'h0000_0200, 3, 1'b0, 1'b1);
        n = 0;
        while (data_q.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("pre_reset_beats", 32'(data_q.size()), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_req_ready", 32'(line_req_ready), 32'd1);
        checkOutput("mid_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("mid_rst_rsp_valid", 32'(line_rsp_valid), 32'd0);
        checkOutput("mid_rst_rsp_last", 32'(line_rsp_last), 32'd0);
        checkOutput("mid_rst_rsp_data", line_rsp_data, 32'd0);
        stray_seen = 0;
        n = 0;
        while ((pend_q.size() > 0 || mem_rsp_valid) && n < 30) begin
            tick();
            if (line_rsp_valid !== 1'b0 || line_req_ready !== 1'b1) stray_seen++;
            n++;
        end
        tick();
        if (line_rsp_valid !== 1'b0) stray_seen++;
        checkOutput("stray_words_ignored", 32'(stray_seen), 32'd0);
        applyStimulus(32'h0000_0080, 1, 1'b0, 1'b1);
        collectLine(200);
        checkLine("after_reset", 32'h0000_0080);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
